instr_fetch_unit: RTL and testbench

- Initiator/reader side of the byte-addressed instruction memory.
- Owns the fetch PC and drives the memory address, with write-enable held low.
- Samples the big-endian 32-bit instruction word and buffers {pc, instr} in a small prefetch FIFO.
- Presents instructions to decode over a valid/ready handshake; supports branch/jump redirect with flush.

---
 rtl/instr_fetch_unit_if.sv | 28 ++
 rtl/instr_fetch_unit.sv | 108 ++++++++++
 tb/tb_instr_fetch_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-fetch bus bundle: memory read port plus the decode valid/ready handshake.
// master = fetch unit side, slave = memory/decode side.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 12
) ();
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_wr;
  logic [31:0]       imem_data_in;
  logic [31:0]       imem_data_out;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst_data;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    output imem_addr, imem_wr, imem_data_in,
    input  imem_data_out,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_addr, imem_wr, imem_data_in,
    output imem_data_out,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC generation, big-endian word capture and a small prefetch FIFO to decode.
// Optional ALIGN_CHECK_EN: misaligned redirects raise a sticky fetch_fault and halt fetching.
module instr_fetch_unit #(
  parameter int ADDR_W     = 12,
  parameter int RESET_PC   = 0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_fault,
  instr_fetch_unit_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] fetch_pc_reg;
  logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next, remain;
  logic [31:0]       data_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];
  logic [31:0]       inst_data_reg, head_data_next;
  logic [ADDR_W-1:0] inst_pc_reg, head_pc_next;
  logic [ADDR_W-1:0] redirect_target;
  logic              halted, full, pop, push;

`ifdef ALIGN_CHECK_EN
  logic halted_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_reg <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      halted_reg <= 1'b1;
    end
  end

  // Misaligned targets are kept verbatim so the faulting address is visible on imem_addr.
  assign redirect_target = redirect_pc;
  assign halted          = halted_reg;
  assign fetch_fault     = halted_reg;
`else
  assign redirect_target = redirect_pc & ~ADDR_W'(3);
  assign halted          = 1'b0;
  assign fetch_fault     = 1'b0;
`endif

  assign full        = (count_reg == CNT_W'(FIFO_DEPTH));
  assign pop         = (count_reg != '0) & bus.inst_ready;
  assign push        = fetch_en & ~redirect_valid & ~halted & (~full | pop);
  assign count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);
  assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
  assign remain      = count_reg - CNT_W'(pop);

  // Head registers take the next surviving entry, or the word being fetched if none is left.
  always_comb begin
    head_data_next = data_mem[rd_ptr_next];
    head_pc_next   = pc_mem[rd_ptr_next];
    if (remain == '0) begin
      head_data_next = bus.imem_data_out;
      head_pc_next   = fetch_pc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= bus.imem_data_out;
      pc_mem[wr_ptr_reg]   <= fetch_pc_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg  <= RESET_PC_A;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      inst_data_reg <= '0;
      inst_pc_reg   <= '0;
    end else if (redirect_valid) begin
      fetch_pc_reg <= redirect_target;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      if (push) begin
        fetch_pc_reg <= fetch_pc_reg + ADDR_W'(4);
        wr_ptr_reg   <= wr_ptr_reg + PTR_W'(1);
      end
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (count_next != '0) begin
        inst_data_reg <= head_data_next;
        inst_pc_reg   <= head_pc_next;
      end
    end
  end

  assign bus.imem_addr    = fetch_pc_reg;
  assign bus.imem_wr      = 1'b0;
  assign bus.imem_data_in = 32'h0;
  assign bus.inst_valid   = (count_reg != '0);
  assign bus.inst_data    = inst_data_reg;
  assign bus.inst_pc      = inst_pc_reg;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: byte memory model, hand-computed expected words.
// Memory: bytes 0x000..0x00F = 00 11 .. FF, every other byte equals its address low byte.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        fetch_fault;
  int          checks   = 0;
  int          failures = 0;

  instr_fetch_unit_if #(.ADDR_W(12)) bus ();

  instr_fetch_unit #(
    .ADDR_W    (12),
    .RESET_PC  (0),
    .FIFO_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_fault   (fetch_fault),
    .bus           (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [11:0] a);
    logic [11:0] prod;
    if (a < 12'h010) begin
      prod = a * 12'd17;
      return prod[7:0];
    end
    return a[7:0];
  endfunction

  always_comb begin
    bus.imem_data_out = {mem_byte(bus.imem_addr),
                         mem_byte(bus.imem_addr + 12'd1),
                         mem_byte(bus.imem_addr + 12'd2),
                         mem_byte(bus.imem_addr + 12'd3)};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [11:0] pc, input logic [31:0] data);
    check_eq({tag, "_valid"}, 32'(bus.inst_valid), 32'd1);
    check_eq({tag, "_pc"}, 32'(bus.inst_pc), 32'(pc));
    check_eq({tag, "_data"}, bus.inst_data, data);
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b1;
    bus.inst_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 12'h000;
    repeat (2) tick();
    check_eq("rst_valid", 32'(bus.inst_valid), 32'd0);
    check_eq("rst_data", bus.inst_data, 32'h0);
    check_eq("rst_pc", 32'(bus.inst_pc), 32'h0);
    check_eq("rst_fault", 32'(fetch_fault), 32'd0);
    check_eq("rst_addr", 32'(bus.imem_addr), 32'h0);
    check_eq("rst_wr", 32'(bus.imem_wr), 32'd0);
    check_eq("rst_wdata", bus.imem_data_in, 32'h0);

    // Streaming with decode always ready
    rst_n = 1'b1;
    tick(); check_head("s1_i0", 12'h000, 32'h00112233);
    tick(); check_head("s1_i1", 12'h004, 32'h44556677);
    tick(); check_head("s1_i2", 12'h008, 32'h8899AABB);

    // Back-pressure fills the FIFO, then drains with no bubble
    rst_n = 1'b0; bus.inst_ready = 1'b0;
    tick();
    check_eq("s2_rst_valid", 32'(bus.inst_valid), 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    check_eq("s2_addr_hold", 32'(bus.imem_addr), 32'h008);
    check_head("s2_stall", 12'h000, 32'h00112233);
    bus.inst_ready = 1'b1;
    tick(); check_head("s2_d1", 12'h004, 32'h44556677);
    tick(); check_head("s2_d2", 12'h008, 32'h8899AABB);

    // Redirect flushes a full FIFO holding 0x010/0x014
    bus.inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 12'h010;
    tick();
    check_eq("s3_flush0_valid", 32'(bus.inst_valid), 32'd0);
    redirect_valid = 1'b0;
    repeat (3) tick();
    check_head("s3_full", 12'h010, 32'h10111213);
    check_eq("s3_addr", 32'(bus.imem_addr), 32'h018);
    bus.inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 12'h100;
    tick();
    check_eq("s3_flush_valid", 32'(bus.inst_valid), 32'd0);
    redirect_valid = 1'b0;
    tick(); check_head("s3_t0", 12'h100, 32'h00010203);
    tick(); check_head("s3_t1", 12'h104, 32'h04050607);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 12'hFFC;
    tick();
    check_eq("s4_flush_valid", 32'(bus.inst_valid), 32'd0);
    redirect_valid = 1'b0;
    tick(); check_head("s4_top", 12'hFFC, 32'hFCFDFEFF);
    tick(); check_head("s4_wrap", 12'h000, 32'h00112233);

    // fetch_en low: FIFO drains, PC frozen
    bus.inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 12'h020;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    fetch_en = 1'b0; bus.inst_ready = 1'b1;
    check_head("s5_h0", 12'h020, 32'h20212223);
    tick(); check_head("s5_h1", 12'h024, 32'h24252627);
    tick();
    check_eq("s5_empty_valid", 32'(bus.inst_valid), 32'd0);
    check_eq("s5_stale_pc", 32'(bus.inst_pc), 32'h024);
    check_eq("s5_addr_frozen", 32'(bus.imem_addr), 32'h028);
    tick();
    check_eq("s5_addr_frozen2", 32'(bus.imem_addr), 32'h028);
    check_eq("s5_wr", 32'(bus.imem_wr), 32'd0);

    // Misaligned redirect
    fetch_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 12'h102;
    tick();
    check_eq("s6_flush_valid", 32'(bus.inst_valid), 32'd0);
    redirect_valid = 1'b0;
    tick();
`ifdef ALIGN_CHECK_EN
    check_eq("s6_fault", 32'(fetch_fault), 32'd1);
    check_eq("s6_halt_valid", 32'(bus.inst_valid), 32'd0);
    check_eq("s6_raw_addr", 32'(bus.imem_addr), 32'h102);
    repeat (3) tick();
    check_eq("s6_halt_valid2", 32'(bus.inst_valid), 32'd0);
    check_eq("s6_fault_sticky", 32'(fetch_fault), 32'd1);
`else
    check_head("s6_aligned", 12'h100, 32'h00010203);
    check_eq("s6_nofault", 32'(fetch_fault), 32'd0);
`endif

    // Reset asserted mid-cycle takes effect without a clock edge
    rst_n = 1'b0;
    #1;
    check_eq("async_valid", 32'(bus.inst_valid), 32'd0);
    check_eq("async_fault", 32'(fetch_fault), 32'd0);
    check_eq("async_data", bus.inst_data, 32'h0);
    check_eq("async_addr", 32'(bus.imem_addr), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check_head("post_rst", 12'h000, 32'h00112233);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
